// File: rtl/expr_tx_if.sv
// Term/character handshake bundle for expr_tx.
// master = term producer and character consumer; slave = expr_tx.
interface expr_tx_if;
  logic       term_valid;
  logic       term_ready;
  logic [3:0] term_digit;
  logic       term_op;
  logic       term_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output term_valid, term_digit, term_op, term_last, out_ready,
    input  term_ready, out_valid, out_char, busy, done, err
  );

  modport slave (
    input  term_valid, term_digit, term_op, term_last, out_ready,
    output term_ready, out_valid, out_char, busy, done, err
  );
endinterface

// File: rtl/expr_tx.sv
// Term FIFO plus serialiser emitting digit/op ASCII expressions.
// Optional EXPR_TX_CHECK_EN: digits > 9 set sticky err and emit "0".
module expr_tx #(
  parameter int unsigned DEPTH = 4
) (
  input logic      clk,
  input logic      clr_n,
  expr_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, DIG, OP, GAP} state_t;

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  state_t        state_q;
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_nx;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [7:0]    out_char_q;
  logic          busy_q, done_q;
  logic          push, pop, hs;
  logic [3:0]    wdig;
  logic [5:0]    head;
  logic [3:0]    nxt_dig;

  assign bus.term_ready = (cnt_q != FULL);
  assign push  = bus.term_valid && bus.term_ready;
  assign hs    = out_valid_q && bus.out_ready;
  assign pop   = hs && (state_q == DIG);
  assign rd_nx = rd_q + AW'(1);
  assign head  = mem_q[rd_q];
  assign nxt_dig = mem_q[rd_nx][5:2];

`ifdef EXPR_TX_CHECK_EN
  logic bad, err_q;
  assign bad  = bus.term_digit > 4'd9;
  assign wdig = bad ? 4'h0 : bus.term_digit;
  always_ff @(posedge clk) begin
    if (!clr_n)
      err_q <= 1'b0;
    else if (push && bad)
      err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign wdig    = bus.term_digit;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= {wdig, bus.term_op, bus.term_last};
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push)
        wr_q <= wr_q + AW'(1);
      if (pop)
        rd_q <= rd_nx;
      cnt_q <= cnt_q + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
      unique case (state_q)
        IDLE, GAP: begin
          if (cnt_q != '0) begin
            state_q     <= DIG;
            out_valid_q <= 1'b1;
            out_char_q  <= asc(head[5:2]);
          end
        end
        DIG: begin
          if (hs) begin
            if (head[0]) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              // next expression starts back-to-back from stored terms
              if (cnt_q > ONE) begin
                state_q    <= DIG;
                out_char_q <= asc(nxt_dig);
              end else begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              state_q    <= OP;
              busy_q     <= 1'b1;
              out_char_q <= head[1] ? 8'h2A : 8'h2B;
            end
          end
        end
        OP: begin
          if (hs) begin
            if (cnt_q != '0) begin
              state_q    <= DIG;
              out_char_q <= asc(head[5:2]);
            end else begin
              state_q     <= GAP;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_expr_tx.sv
// Scoreboard bench for expr_tx: expression model feeds a queue,
// negedge monitor compares every character handshake.
module tb_expr_tx;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] ch;
    bit         busy;
    bit         last;
    bit         dig;
  } ent_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  expr_tx_if bus ();

  expr_tx #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  ent_t sb[$];
  int   hs_cyc[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   occ = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   pcnt = 0;
  bit   mon_en = 0;
  bit   in_expr = 0;
  bit   exp_done = 0;
  bit   exp_err = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_char = 8'h00;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] d, input logic op,
                            input logic last);
    ent_t e;
    logic [7:0] c;
    c = 8'h30 + {4'h0, d};
`ifdef EXPR_TX_CHECK_EN
    if (d > 4'd9) begin
      c = 8'h30;
      exp_err = 1;
    end
`endif
    e.ch = c; e.busy = in_expr; e.last = last; e.dig = 1;
    sb.push_back(e);
    if (!last) begin
      e.ch = op ? 8'h2A : 8'h2B;
      e.busy = 1; e.last = 0; e.dig = 0;
      sb.push_back(e);
    end
    in_expr = !last;
  endtask

  always @(negedge clk) begin
    ent_t e;
    bit pop;
    if (mon_en) begin
      cyc++;
      pop = 0;
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("term_ready", 32'(bus.term_ready), 32'(occ != DEPTH));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_char", 32'(bus.out_char), 32'(prev_char));
      end
      exp_done = 0;
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_char: got %0h expected none", bus.out_char);
        end else begin
          e = sb.pop_front();
          chk("char", 32'(bus.out_char), 32'(e.ch));
          chk("busy", 32'(bus.busy), 32'(e.busy));
          exp_done = e.last;
          pop = e.dig;
        end
      end
      occ = occ + ((bus.term_valid && bus.term_ready) ? 1 : 0)
                - (pop ? 1 : 0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_char  = bus.out_char;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pcnt++;
    unique case (rmode)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      2: bus.out_ready = 1'($urandom_range(0, 1));
      3: bus.out_ready = pat[pcnt % 4];
      default: ;
    endcase
  endtask

  task automatic push_term(input logic [3:0] d, input logic op,
                           input logic last);
    int g = 0;
    bus.term_valid = 1'b1;
    bus.term_digit = d;
    bus.term_op    = op;
    bus.term_last  = last;
    forever begin
      @(negedge clk);
      if (bus.term_ready) begin
        model_push(d, op, last);
        tick();
        break;
      end
      tick();
      g++;
      if (g > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL push_timeout: got term_ready 0 expected 1");
        break;
      end
    end
    bus.term_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 400) begin
      tick();
      n++;
    end
    n_chk++;
    if (n >= 400) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    mon_en = 0;
    clr_n = 1'b0;
    bus.term_valid = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
    sb.delete();
    occ = 0; in_expr = 0; exp_done = 0; exp_err = 0; prev_stall = 0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_char", 32'(bus.out_char), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_ready", 32'(bus.term_ready), 32'd1);
    mon_en = 1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.term_valid = 1'b0;
    bus.term_digit = 4'h0;
    bus.term_op    = 1'b0;
    bus.term_last  = 1'b0;
    bus.out_ready  = 1'b0;
    do_reset();

    rmode = 1;
    hs_cyc.delete();
    push_term(4'd3, 1'b0, 1'b0);
    push_term(4'd4, 1'b1, 1'b0);
    push_term(4'd7, 1'b0, 1'b1);
    drain();
    chk("t1_count", 32'(hs_cyc.size()), 32'd5);
    if (hs_cyc.size() == 5)
      for (int i = 1; i < 5; i++)
        chk("t1_consec", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd1);

    rmode = 3;
    push_term(4'd3, 1'b0, 1'b0);
    push_term(4'd4, 1'b1, 1'b0);
    push_term(4'd7, 1'b0, 1'b1);
    drain();

    rmode = 0;
    tick();
    push_term(4'd1, 1'b0, 1'b0);
    push_term(4'd2, 1'b1, 1'b0);
    push_term(4'd3, 1'b0, 1'b0);
    push_term(4'd4, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_ready", 32'(bus.term_ready), 32'd0);
    tick();
    rmode = 1;
    push_term(4'd5, 1'b0, 1'b1);
    drain();

    push_term(4'd5, 1'b0, 1'b0);
    repeat (5) tick();
    @(negedge clk);
    chk("gap_valid", 32'(bus.out_valid), 32'd0);
    chk("gap_busy", 32'(bus.busy), 32'd1);
    tick();
    push_term(4'd2, 1'b0, 1'b1);
    drain();

    push_term(4'd12, 1'b0, 1'b1);
    drain();
    repeat (3) tick();
    chk("err_sticky", 32'(bus.err), 32'(exp_err));

    rmode = 0;
    push_term(4'd1, 1'b0, 1'b0);
    push_term(4'd2, 1'b0, 1'b0);
    push_term(4'd3, 1'b0, 1'b1);
    rmode = 4;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("op_char", 32'(bus.out_char), 32'h2B);
    chk("op_busy", 32'(bus.busy), 32'd1);
    tick();
    do_reset();
    rmode = 1;
    push_term(4'd9, 1'b0, 1'b1);
    drain();

    rmode = 2;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_term(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                (i == 149) ? 1'b1 : 1'($urandom_range(0, 2) == 0));
    end
    rmode = 1;
    drain();
    chk("err_final", 32'(bus.err), 32'(exp_err));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/expr_tx.md
# expr_tx

Character-stream transmitter for the digit/operator expression protocol: accepts expression terms (one decimal digit plus a following operator) through a valid/ready port, buffers them in a small FIFO, and serialises them as 8-bit ASCII characters, one character per accepted handshake. Every emitted expression has the form digit, then zero or more (op, digit) pairs, with op being "+" or "*". The block sits upstream of the expression recogniser and drives the same 8-bit character input that the recogniser samples.

## Interface
- DEPTH, 4, term FIFO depth (power of 2, ≥2)
- clk  input  1  clock, all logic on rising edge
- clr_n  input  1  synchronous active-low reset
- term_valid  input  1  term offered
- term_ready  output  1  FIFO can accept a term (= !full)
- term_digit  input  4  digit value 0–9
- term_op  input  1  operator following this digit: 0 = "+", 1 = "*"; ignored when term_last=1
- term_last  input  1  final term of the expression
- out_valid  output  1  out_char holds a character
- out_ready  input  1  downstream accepts the character
- out_char  output  8  ASCII character
- busy  output  1  an expression is in progress (first char sent, last digit not yet sent)
- done  output  1  one-cycle pulse after the last digit of an expression transfers
- err  output  1  sticky: digit > 9 was accepted (only with EXPR_TX_CHECK_EN)

## Operation
- Term push: term_valid && term_ready writes {digit, op, last} into FIFO.
- FSM states: IDLE (between expressions, out_valid=0), DIG (out_valid=1, out_char = "0"+head digit), OP (out_valid=1, out_char = "+" or "*" from the term just sent), GAP (mid-expression, FIFO empty, out_valid=0, busy=1).
- IDLE → DIG when FIFO non-empty.
- DIG, handshake: pop head. If last=1: done=1 next cycle; busy falls; next state DIG if FIFO still non-empty after the pop, else IDLE. If last=0: latch op, go OP; busy=1.
- OP, handshake: next state DIG if FIFO non-empty, else GAP.
- GAP → DIG when FIFO non-empty.
- No handshake: state, out_char, and out_valid hold. out_char never changes while out_valid=1 && out_ready=0.
- Simultaneous push and pop: both take effect; occupancy unchanged. A push into an empty FIFO does not bypass to out_char.
- Full FIFO: term_ready=0; term_valid is ignored.
- Pointers wrap modulo DEPTH; occupancy counter has log2(DEPTH)+1 bits.

## Timing
- Reset (clr_n=0 at an edge): state IDLE, FIFO empty, out_valid=0, out_char=8'h00, busy=0, done=0, err=0, term_ready=1 from the following cycle.
- Reset mid-expression discards all buffered terms and any partial expression. No done pulse is produced.
- Latency: a term pushed at edge N into an empty FIFO in IDLE/GAP gives out_valid=1 after edge N+1.
- Sustained rate with out_ready=1 and FIFO non-empty: one character per cycle, including back-to-back expressions (last digit then next first digit).
- done is asserted for exactly the cycle after the last-digit handshake edge.
- busy rises with the first OP entry and falls at the same edge that raises done.
- A single-term expression never raises busy.

## Configuration
- EXPR_TX_CHECK_EN defined: a pushed digit > 9 sets err (sticky until reset), and that digit is stored and emitted as "0".
- EXPR_TX_CHECK_EN undefined: err is tied 0, and out_char = 8'h30 + digit unchecked, so values 10–15 emit ":" through "?".

## Test plan
- Push terms {3,+,0},{4,*,0},{7,-,1} with out_ready=1 → out_char sequence "3","+","4","*","7" on consecutive cycles, one done pulse after "7", busy high from "+" through "*".
- Same stream with out_ready toggling 1,0,0,1 → each character held stable during stalls, with no drop or duplicate.
- Push DEPTH terms with out_ready=0 → term_ready=0 after the fourth push (DEPTH=4). Then raise out_ready with a concurrent push → occupancy stays constant and all characters arrive in order.
- Push {5,+,0}, wait 5 cycles, then push {2,+,1} → "5","+", then GAP (out_valid=0, busy=1), then "2", then done.
- Assert clr_n=0 in OP state with 2 terms buffered → the next cycle has all outputs at reset values, and a new {9,+,1} push yields "9" followed by done.
- With EXPR_TX_CHECK_EN defined, push {12,+,1} → out_char "0" and err=1, which persists until clr_n=0.
